// File: rtl/lamp_fader.sv
// Lamp output stage: soft-start/soft-stop brightness ramp driving a registered PWM lamp output.
// Latency: state/duty/lamp_on/ramping update on the sampling edge; pwm_out lags duty by one cycle.
// Backpressure: none; saida_in is a level request sampled every cycle and is never stalled.
//
// Ports:
//   clk      - system clock
//   rst      - asynchronous, active-high reset
//   saida_in - lamp request from the controller (1 = on), synchronous to clk
//   pwm_out  - registered PWM drive to the lamp
//   duty     - current brightness level, 0 .. MAX_DUTY
//   lamp_on  - high while fully on
//   ramping  - high while ramping up or down
module lamp_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP_T   = 20,
    parameter int MAX_DUTY = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                saida_in,
    output logic                pwm_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                lamp_on,
    output logic                ramping
);

    localparam int TW = (STEP_T > 1) ? $clog2(STEP_T) : 1;
    localparam logic [TW-1:0]       STEP_LAST = TW'(STEP_T - 1);
    localparam logic [TW-1:0]       TIMER_ONE = TW'(1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [PWM_BITS-1:0]   duty_nxt;
    logic [TW-1:0]         timer;
    logic [TW-1:0]         timer_nxt;
    logic                  tick;
    logic [PWM_BITS-1:0]   pwm_cnt;

    // State, duty and step timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            duty  <= '0;
            timer <= '0;
        end else begin
            state <= state_nxt;
            duty  <= duty_nxt;
            timer <= timer_nxt;
        end
    end

    // With STEP_T = 1 the timer is pinned at 0, so every cycle is a tick.
    assign tick = (timer == STEP_LAST);

    // Next-state logic. The timer defaults to 0, which covers clearing on
    // every state entry, while settled, and after each tick. A direction
    // reversal is checked before the tick so it wins and holds duty.
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        timer_nxt = '0;
        case (state)
            ST_OFF: begin
                duty_nxt = '0;
                if (saida_in) begin
                    state_nxt = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (!saida_in) begin
                    state_nxt = ST_RAMP_DOWN;
                end else if (tick) begin
                    // Saturate at full-on; a reversal can re-enter the up
                    // ramp already at the top level.
                    if (duty >= (DUTY_MAX - DUTY_ONE)) begin
                        duty_nxt  = DUTY_MAX;
                        state_nxt = ST_ON;
                    end else begin
                        duty_nxt = duty + DUTY_ONE;
                    end
                end else begin
                    timer_nxt = timer + TIMER_ONE;
                end
            end
            ST_ON: begin
                duty_nxt = DUTY_MAX;
                if (!saida_in) begin
                    state_nxt = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (saida_in) begin
                    state_nxt = ST_RAMP_UP;
                end else if (tick) begin
                    // Saturate at zero; a short on-pulse can leave the down
                    // ramp starting from level 0.
                    if (duty <= DUTY_ONE) begin
                        duty_nxt  = '0;
                        state_nxt = ST_OFF;
                    end else begin
                        duty_nxt = duty - DUTY_ONE;
                    end
                end else begin
                    timer_nxt = timer + TIMER_ONE;
                end
            end
            default: begin
                state_nxt = ST_OFF;
                duty_nxt  = '0;
            end
        endcase
    end

    // Free-running PWM counter and registered comparator. All-ones duty is
    // forced high so full-scale gives a continuous on level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_ONE;
            pwm_out <= (&duty) ? 1'b1 : (pwm_cnt < duty);
        end
    end

    assign lamp_on = (state == ST_ON);
    assign ramping = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);

endmodule
